// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // 100 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Total clk cycles for one frame: start + data + optional parity + stop bits.
  function automatic int frame_cycles(input int data_bits, input int parity_en,
                                      input int stop_bits,
                                      input int clks_per_bit = DEFAULT_CLKS_PER_BIT);
    return (1 + data_bits + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1, ticks on the terminal count and wraps.
// pre_tick marks the cycle before the terminal count so callers can register
// outputs that must line up with the last cycle of a bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TC_VAL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_VAL = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] count;

  assign tick     = (count == TC_VAL);
  assign pre_tick = (count == PRE_VAL);

  // Free-running bit-time counter; clear realigns it to a new frame.
  always_ff @(posedge clk) begin
    if (reset || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops a word from the upstream FIFO when idle and enabled,
// then shifts it out LSB-first with optional parity and 1 or 2 stop bits.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high; pops the FIFO head when tx_en and fifo_valid
// START  | start bit, line low for one bit time
// DATA   | data bits LSB-first from the shift register
// PARITY | parity bit latched at capture time
// STOP   | line high for STOP_BITS bit times; frame_done on last cycle
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_en,
  input  logic [DATA_BITS-1:0] fifo_data,
  input  logic                 fifo_valid,
  output logic                 fifo_pop,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  tx_state_t            state_q, state_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_nxt;
  logic                 par_q, par_nxt;
  logic                 tx_nxt, busy_nxt, done_nxt;
  logic                 bit_tick, bit_pre_tick;

  assign fifo_pop = (state_q == IDLE) && tx_en && fifo_valid && !reset;

  // Restarting the baud counter on the pop makes the start bit exactly one bit time.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (fifo_pop),
    .tick    (bit_tick),
    .pre_tick(bit_pre_tick)
  );

  // Next-state, shift and bit-count logic; outputs derive from the next state
  // so the pin is driven straight from a flop.
  always_comb begin
    state_nxt   = state_q;
    shift_nxt   = shift_q;
    bit_cnt_nxt = bit_cnt_q;
    par_nxt     = par_q;
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          state_nxt = START;
          shift_nxt = fifo_data;
          par_nxt   = (^fifo_data) ^ (PARITY_ODD != 0);
        end
      end
      START: begin
        if (bit_tick) state_nxt = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_nxt = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_nxt = bit_cnt_q + BCW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_nxt = STOP;
      end
      STOP: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_nxt = IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt_q + BCW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state_q) bit_cnt_nxt = '0;

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = par_q;
      default: tx_nxt = 1'b1;
    endcase

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_q == STOP) && (bit_cnt_q == LAST_STOP) && bit_pre_tick;
  end

  // State and registered pin outputs; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      shift_q    <= shift_nxt;
      bit_cnt_q  <= bit_cnt_nxt;
      par_q      <= par_nxt;
      tx         <= tx_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three instances (8N1, 8E1, 7N2) at 4 clks/bit.
module tb_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en   [3];
  logic       fv   [3];
  logic [7:0] fdat0, fdat1;
  logic [6:0] fdat2;
  logic       pop_w [3];
  logic       tx_w  [3];
  logic       busy_w[3];
  logic       fd_w  [3];

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u_8n1 (
    .clk(clk), .reset(rst), .tx_en(en[0]), .fifo_data(fdat0), .fifo_valid(fv[0]),
    .fifo_pop(pop_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
    .clk(clk), .reset(rst), .tx_en(en[1]), .fifo_data(fdat1), .fifo_valid(fv[1]),
    .fifo_pop(pop_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));

  uart_tx #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0)) u_7n2 (
    .clk(clk), .reset(rst), .tx_en(en[2]), .fifo_data(fdat2), .fifo_valid(fv[2]),
    .fifo_pop(pop_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));

  int db_c[3] = '{8, 8, 7};
  int pe_c[3] = '{0, 1, 0};
  int sb_c[3] = '{1, 1, 2};

  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  logic [6:0] fq2[$];
  exp_t       sbq[$];

  int          checks = 0;
  int          errors = 0;
  logic        s_pop[3];
  logic        s_fd [3];
  int          pop_cnt[3];
  logic        act[3];
  logic        bsy_ok[3];
  int          cnt[3];
  logic [63:0] cap[3];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endfunction

  function automatic void refresh();
    fv[0] = (fq0.size() != 0);
    fv[1] = (fq1.size() != 0);
    fv[2] = (fq2.size() != 0);
    fdat0 = fv[0] ? fq0[0] : 8'h00;
    fdat1 = fv[1] ? fq1[0] : 8'h00;
    fdat2 = fv[2] ? fq2[0] : 7'h00;
  endfunction

  // One clock: sample at negedge, model FIFO pops after the edge, drive at +1.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      s_pop[i] = pop_w[i];
      s_fd[i]  = fd_w[i];
      if (pop_w[i]) pop_cnt[i]++;
    end
    @(posedge clk);
    #1;
    if (s_pop[0]) void'(fq0.pop_front());
    if (s_pop[1]) void'(fq1.pop_front());
    if (s_pop[2]) void'(fq2.pop_front());
    refresh();
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!s_fd[i] && n < budget);
    if (!s_fd[i]) fail($sformatf("timeout_frame_done_inst%0d", i));
  endtask

  function automatic void check_frame(input int i);
    int         nb;
    logic       shape_ok;
    logic [7:0] d;
    logic       p;
    exp_t       e;
    nb = 1 + db_c[i] + pe_c[i] + sb_c[i];
    chk($sformatf("frame_len_inst%0d", i), cnt[i], nb * CPB);
    shape_ok = bsy_ok[i];
    for (int k = 0; k < nb; k++)
      for (int j = 1; j < CPB; j++)
        if (cap[i][k*CPB+j] !== cap[i][k*CPB]) shape_ok = 1'b0;
    if (cap[i][0] !== 1'b0) shape_ok = 1'b0;
    for (int k = nb - sb_c[i]; k < nb; k++)
      if (cap[i][k*CPB] !== 1'b1) shape_ok = 1'b0;
    chk($sformatf("frame_shape_inst%0d", i), shape_ok, 1);
    d = 8'h00;
    for (int k = 0; k < db_c[i]; k++) d[k] = cap[i][(1+k)*CPB];
    p = cap[i][(1+db_c[i])*CPB];
    if (sbq.size() == 0) begin
      fail($sformatf("unexpected_frame_inst%0d_data_%0h", i, d));
    end else begin
      e = sbq.pop_front();
      chk("frame_inst", i, e.inst);
      chk($sformatf("frame_data_inst%0d", i), d, e.data);
      if (pe_c[i] != 0) chk($sformatf("frame_parity_inst%0d", i), p, e.par);
    end
  endfunction

  // Line monitor: records tx from the cycle after each pop, checks on frame_done.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          act[i] = 1'b0;
        end else begin
          if (act[i]) begin
            if (cnt[i] > 63) begin
              fail($sformatf("frame_overrun_inst%0d", i));
              act[i] = 1'b0;
            end else begin
              cap[i][cnt[i]] = tx_w[i];
              if (!busy_w[i]) bsy_ok[i] = 1'b0;
              cnt[i]++;
            end
          end
          if (fd_w[i]) begin
            if (!act[i]) begin
              chk($sformatf("spurious_done_inst%0d", i), act[i], 1);
            end else begin
              check_frame(i);
              act[i] = 1'b0;
            end
          end
          if (pop_w[i]) begin
            if (act[i]) fail($sformatf("pop_mid_frame_inst%0d", i));
            act[i]    = 1'b1;
            cnt[i]    = 0;
            bsy_ok[i] = 1'b1;
            cap[i]    = '0;
          end
        end
      end
    end
  endtask

  initial begin
    logic bad;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; pop_cnt[i] = 0; act[i] = 1'b0; cnt[i] = 0; cap[i] = '0; bsy_ok[i] = 1'b1;
      s_pop[i] = 1'b0; s_fd[i] = 1'b0;
    end
    rst = 1'b1;
    refresh();
    fork
      monitor_loop();
    join_none

    // Reset state
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tx_inst%0d", i), tx_w[i], 1);
      chk($sformatf("rst_busy_inst%0d", i), busy_w[i], 0);
      chk($sformatf("rst_done_inst%0d", i), fd_w[i], 0);
      chk($sformatf("rst_pop_inst%0d", i), pop_w[i], 0);
    end
    rst = 1'b0;
    tick();

    // 8N1 single frame 0xA5
    fq0.push_back(8'hA5); sbq.push_back('{0, 8'hA5, 1'b0});
    refresh();
    en[0] = 1'b1;
    wait_done(0, 200);
    chk("8n1_busy_after", busy_w[0], 0);
    chk("8n1_pop_count", pop_cnt[0], 1);

    // 8E1 back-to-back 0xA5 (parity 0) then 0x07 (parity 1)
    fq1.push_back(8'hA5); sbq.push_back('{1, 8'hA5, 1'b0});
    fq1.push_back(8'h07); sbq.push_back('{1, 8'h07, 1'b1});
    refresh();
    en[1] = 1'b1;
    wait_done(1, 200);
    chk("b2b_idle_busy", busy_w[1], 0);
    tick();
    chk("b2b_pop_next", s_pop[1], 1);
    wait_done(1, 200);
    chk("8e1_pop_count", pop_cnt[1], 2);

    // tx_en low holds off 0x3C; re-enable pops on the next cycle
    en[0] = 1'b0;
    fq0.push_back(8'h3C); sbq.push_back('{0, 8'h3C, 1'b0});
    refresh();
    bad = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (s_pop[0] || tx_w[0] !== 1'b1) bad = 1'b1;
    end
    chk("hold_no_pop_tx_high", bad, 0);
    en[0] = 1'b1;
    tick();
    chk("reenable_pop", s_pop[0], 1);
    wait_done(0, 200);

    // Drop tx_en during data bit 3 of 0x55 with 0xAA queued
    fq0.push_back(8'h55); sbq.push_back('{0, 8'h55, 1'b0});
    fq0.push_back(8'hAA); sbq.push_back('{0, 8'hAA, 1'b0});
    refresh();
    tick();
    chk("en_drop_first_pop", s_pop[0], 1);
    for (int n = 0; n < 17; n++) tick();
    en[0] = 1'b0;
    wait_done(0, 200);
    bad = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (s_pop[0]) bad = 1'b1;
    end
    chk("en_drop_no_pop", bad, 0);
    chk("en_drop_valid_held", fv[0], 1);
    en[0] = 1'b1;
    wait_done(0, 200);

    // Reset for one cycle during DATA of 0xF0 (frame abandoned, no expectation)
    fq0.push_back(8'hF0);
    refresh();
    tick();
    chk("rst_mid_pop", s_pop[0], 1);
    for (int n = 0; n < 10; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_tx", tx_w[0], 1);
    chk("rst_mid_busy", busy_w[0], 0);
    chk("rst_mid_fifo_pop", pop_w[0], 0);
    bad = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (s_fd[0]) bad = 1'b1;
    end
    chk("rst_mid_no_done", bad, 0);
    fq0.push_back(8'h81); sbq.push_back('{0, 8'h81, 1'b0});
    refresh();
    wait_done(0, 200);

    // 7N2 frame 0x7F
    fq2.push_back(7'h7F); sbq.push_back('{2, 8'h7F, 1'b0});
    refresh();
    en[2] = 1'b1;
    wait_done(2, 200);
    chk("7n2_pop_count", pop_cnt[2], 1);

    tick(); tick();
    chk("scoreboard_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter that drains the byte FIFO directly downstream of it.
- Pops one word whenever idle, enabled and FIFO non-empty, then shifts it out LSB-first: start bit, DATA_BITS data bits, optional parity, STOP_BITS stop bits.
- Drives the board TX pin. Provides busy and done status for the bus-side register block.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8); also the width of fifo_data.
- CLKS_PER_BIT, 868, clk cycles per bit time (>=2); 868 = 100 MHz / 115200.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- PARITY_EN, 0, 1 = insert parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tx_en  input  1  permits new frames to start; does not abort a frame in progress
- fifo_data  input  DATA_BITS  FIFO head word (combinational from FIFO)
- fifo_valid  input  1  FIFO non-empty (FIFO data_out_valid)
- fifo_pop  output  1  one-cycle pop strobe to FIFO
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress (state != IDLE)
- frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset (sync, active-high, highest priority): state=IDLE, tx=1, fifo_pop=0, busy=0, frame_done=0, counters=0, shift register=0.
- Reset asserted mid-frame: line returns to 1 on the next edge; the partial frame is abandoned; the popped word is lost.
- fifo_pop is combinational: (state==IDLE) && tx_en && fifo_valid && !reset.
- The word is captured into the shift register in the same cycle as the pop.
- Pops only in IDLE, so there is at most one pop per frame and never a pop while fifo_valid=0.
- Latency: pop in cycle N, tx=0 (start bit) from cycle N+1, registered output.
- State machine (uart_pkg::tx_state_t):
  - IDLE: tx=1. On pop, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0]. Shift right at each bit boundary. After DATA_BITS bits go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx=^data XOR PARITY_ODD, computed at capture, for one bit time; then STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; frame_done pulses on the final cycle; then IDLE.
- Back-to-back frames: IDLE lasts exactly one cycle between frames if the FIFO is still non-empty. That idle cycle is permitted and counts as extra stop time.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Baud counter: $clog2(CLKS_PER_BIT) bits. Counts 0..CLKS_PER_BIT-1; a bit_tick is generated at terminal count; wraps to 0.
  - Cleared on the pop cycle so the start bit is exactly CLKS_PER_BIT long.
- Bit counter: $clog2(DATA_BITS+1) bits. Counts data bits in DATA and stop bits in STOP; cleared on every state change.
- tx_en deasserted mid-frame: the frame completes normally and no new pop follows. Reasserting tx_en while the FIFO is non-empty pops on the next cycle.
- fifo_data is sampled only on the pop cycle; later changes do not affect the frame.
- tx, busy and frame_done are registered (glitch-free pin).

Decomposition:
- Package uart_pkg:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP}
  - DEFAULT_CLKS_PER_BIT constant
  - function frame_cycles(data_bits, parity_en, stop_bits)
  - The future uart_rx shares all of these.
- Sub-module uart_baud_gen: counter with clear input and tick output, parameter CLKS_PER_BIT. Reused by uart_rx.
- FSM and shift register live in uart_tx.

Test Plan:
- CLKS_PER_BIT=4, 8N1, FIFO loaded with 0xA5, tx_en=1 -> one fifo_pop pulse; tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles; frame_done at cycle 40 after the pop; busy high for 40 cycles.
- PARITY_EN=1, PARITY_ODD=0, send 0xA5 then 0x07 -> parity bits 0 and 1; frame 44 cycles each; exactly one IDLE cycle between frames; two pops total.
- tx_en=0 with FIFO holding 0x3C -> no pop and tx=1 for 100 cycles; raise tx_en -> pop on the next cycle, frame 0x3C follows.
- Drop tx_en during data bit 3 of 0x55 with 0xAA queued -> 0x55 completes intact; 0xAA is not popped; fifo_valid stays 1.
- Assert reset for 1 cycle during DATA of 0xF0 -> tx=1, busy=0, fifo_pop=0 next cycle; no frame_done; the next queued byte then transmits cleanly.
- STOP_BITS=2, DATA_BITS=7, send 0x7F -> 7 data bits of 1 then 8 stop cycles; frame 40 cycles; frame_done only on the last cycle.
